fp_norm_round_pipe: RTL and testbench
=====================================

Name: fp_norm_round_pipe

Overview:
- Parameterised, 3-stage pipelined normalise-and-round back end for the floating-point adder/subtractor datapath.
- Takes the raw sign, exponent and extended mantissa (carry, hidden, fraction, GRS) from the add/sub core.
- Produces a packed IEEE-754-style result with selectable rounding mode, subnormal handling, overflow saturation and exception flags.
- Uses a valid/ready handshake with full backpressure.

Parameters:
- EXP_W, 5, exponent field width
- MAN_W, 10, stored fraction width
- MW (derived, not overridable), MAN_W+5, extended mantissa width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent aligned to the hidden-bit position
- in_mant  in  MW  extended mantissa: [MW-1] carry, [MW-2] hidden, [MW-3:3] fraction, [2] guard, [1] round, [0] sticky
- in_rnd  in  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  1+EXP_W+MAN_W  packed result {sign, exp, frac}
- out_flags  out  4  {overflow, underflow, inexact, zero}

Behaviour:
- Reset (asynchronous): all stage valids are 0; out_valid=0, out_result=0, out_flags=0. In-flight beats are discarded, including on reset mid-stream.
- Latency and throughput: 3 cycles from accept to out_valid; one beat per cycle.
- Stall: stall = out_valid & ~out_ready. On stall, all stages hold and in_ready=0. in_ready = ~out_valid | out_ready, which is a combinational path from out_ready and is permitted.
- Beat order is preserved. No beat may be dropped or duplicated.
- S1, carry handling:
  - carry=1: shift right by 1; the bit shifted out ORs into sticky; exponent+1.
  - carry=0: count leading zeros over [MW-2:0].
  - exp_eff = max(in_exp, 1).
- S2, left shift:
  - shift = min(lzc, exp_eff-1).
  - Mantissa shifted left by shift; exponent = exp_eff - shift.
  - If the hidden bit is still 0 after the shift, the encoded exponent is 0 (subnormal).
  - All-zero mantissa gives a zero result with exp=0, sign=in_sign, zero flag set.
- S3, rounding: LSB=fraction bit 3, G=bit 2, R=bit 1, S=bit 0.
  - RNE: inc = G & (R|S|LSB)
  - RTZ: inc = 0
  - toward +inf: inc = ~sign & (G|R|S)
  - toward -inf: inc = sign & (G|R|S)
- Fraction carry-out on increment: exponent+1, fraction=0. A subnormal that rounds up becomes the minimum normal (exp=1).
- Overflow, when the final exponent is at least 2^EXP_W-1:
  - RNE: ±inf
  - RTZ: ±max finite
  - toward +inf: +inf if positive, else -max finite
  - toward -inf: -inf if negative, else +max finite
  - overflow=1 and inexact=1 in every case.
- inexact = G|R|S after normalisation, or overflow.
- underflow = (encoded exponent before rounding is 0) & inexact.
- zero = final exponent and fraction both 0.
- in_rnd is sampled with its beat and travels down the pipe alongside it.

Test Plan (defaults EXP_W=5, MAN_W=10, MW=15):
1. Carry: sign=0, exp=15, mant=15'h4000 (carry only), RNE -> out_result=16'h4000, flags=0000, 3 cycles after accept.
2. Cancellation: exp=15, mant=15'h0008 -> lzc=10 -> 16'h1400, flags=0000. Subnormal: exp=1, mant=15'h1000 -> 16'h0200, flags=0000. Zero: sign=1, mant=0 -> 16'h8000, zero=1.
3. Rounding:
   - exp=15, hidden=1, frac=0x001, GRS=100, RNE -> 16'h3C02, inexact=1.
   - frac=0x000, GRS=100, RNE -> 16'h3C00, inexact=1.
   - frac=0x000, GRS=111, RTZ -> 16'h3C00.
   - frac=0x000, GRS=111, toward +inf -> 16'h3C01.
   - frac=0x3FF, GRS=110, RNE -> 16'h4000.
4. Overflow: exp=30, carry=1, sign=0:
   - RNE -> 16'h7C00, overflow=1, inexact=1.
   - RTZ -> 16'h7BFF.
   - sign=1, toward +inf -> 16'hFBFF.
5. Backpressure: 6 back-to-back beats with out_ready low for 3 cycles mid-stream -> all 6 results arrive in order, none lost; in_ready=0 during the stall.
6. Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 and out_result=0 immediately; a new beat after reset release emerges correctly 3 cycles later.

Source files
------------

// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalise-and-round back end for the FP add/sub datapath.
// S1 folds the carry and counts leading zeros, S2 normalises, S3 rounds and packs.
module fp_norm_round_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+4:0]         in_mant,
    input  logic [1:0]               in_rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [3:0]               out_flags
);
    localparam int MW     = MAN_W + 5;
    localparam int XW     = EXP_W + 2;
    localparam int LZW    = $clog2(MW);
    localparam int STAGES = 3;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    // Carry bit is folded away in S1, so later stages carry MW-1 mantissa bits.
    typedef struct packed {
        logic            sign;
        logic [1:0]      rnd;
        logic [XW-1:0]   exp;
        logic [MW-2:0]   mant;
        logic [LZW-1:0]  lzc;
    } s1_t;

    typedef struct packed {
        logic            sign;
        logic [1:0]      rnd;
        logic [XW-1:0]   exp;
        logic [MW-2:0]   mant;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic [STAGES:1] vld_pipe;
    logic            stall, accept;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;

    // S1: carry fold, exponent floor at 1, leading-zero count
    logic [XW-1:0] exp_eff;
    always_comb begin
        exp_eff     = (in_exp == '0) ? XW'(1) : XW'(in_exp);
        s1_d.sign   = in_sign;
        s1_d.rnd    = in_rnd;
        s1_d.lzc    = LZW'(MW - 1);
        if (in_mant[MW-1]) begin
            s1_d.mant = {in_mant[MW-1:2], in_mant[1] | in_mant[0]};
            s1_d.exp  = exp_eff + XW'(1);
            s1_d.lzc  = '0;
        end else begin
            s1_d.mant = in_mant[MW-2:0];
            s1_d.exp  = exp_eff;
            for (int i = 0; i < MW - 1; i++)
                if (in_mant[i]) s1_d.lzc = LZW'(MW - 2 - i);
        end
    end

    // S2: left shift limited so the exponent never drops below 1
    logic [XW-1:0] lz_x, exp_m1, sh, exp_n;
    logic [MW-2:0] mant_sh;
    always_comb begin
        lz_x       = XW'(s1_q.lzc);
        exp_m1     = s1_q.exp - XW'(1);
        sh         = (lz_x < exp_m1) ? lz_x : exp_m1;
        mant_sh    = s1_q.mant << sh;
        exp_n      = s1_q.exp - sh;
        s2_d.sign  = s1_q.sign;
        s2_d.rnd   = s1_q.rnd;
        s2_d.mant  = mant_sh;
        s2_d.exp   = mant_sh[MW-2] ? exp_n : '0;
    end

    // S3: rounding, overflow saturation, flags
    logic [MAN_W-1:0]   frac, frac_r;
    logic               g, r, s, inc, ovf, inexact, to_inf;
    logic [MAN_W+1:0]   sum;
    logic [XW-1:0]      exp_r;
    logic [EXP_W+MAN_W:0] res;
    logic [3:0]         flags;
    always_comb begin
        frac = s2_q.mant[MW-3:3];
        g    = s2_q.mant[2];
        r    = s2_q.mant[1];
        s    = s2_q.mant[0];
        case (s2_q.rnd)
            2'b00:   inc = g & (r | s | frac[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~s2_q.sign & (g | r | s);
            default: inc = s2_q.sign & (g | r | s);
        endcase
        sum    = {1'b0, s2_q.mant[MW-2], frac} + (MAN_W+2)'(inc);
        frac_r = sum[MAN_W-1:0];
        exp_r  = s2_q.exp;
        if (sum[MAN_W+1])
            exp_r = s2_q.exp + XW'(1);
        else if (s2_q.exp == '0 && sum[MAN_W])
            exp_r = XW'(1);
        ovf     = (exp_r >= EXP_MAX);
        inexact = g | r | s | ovf;
        case (s2_q.rnd)
            2'b00:   to_inf = 1'b1;
            2'b01:   to_inf = 1'b0;
            2'b10:   to_inf = ~s2_q.sign;
            default: to_inf = s2_q.sign;
        endcase
        res = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
        if (ovf)
            res = to_inf ? {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        flags = {ovf, (s2_q.exp == '0) & inexact, inexact,
                 ~ovf & (exp_r == '0) & (frac_r == '0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept)      s1_q <= s1_d;
            if (vld_pipe[1]) s2_q <= s2_d;
            if (vld_pipe[2]) begin
                out_result <= res;
                out_flags  <= flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe: hand-computed vectors, scoreboard queue,
// latency, backpressure and mid-stream reset.
module tb_fp_norm_round_pipe;
    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic [14:0] in_mant = '0;
    logic [1:0]  in_rnd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [3:0]  out_flags;

    fp_norm_round_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [4:0]  ex;
        logic [14:0] mt;
        logic [1:0]  rm;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    vec_t tv [17];
    exp_t sb [$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s[%0d]: got %h required %h", tag, idx, obs, req);
        end
    endtask

    // Drive one beat, push its expectation just before the accepting edge.
    task automatic send(input int idx);
        int k;
        in_valid = 1'b1;
        in_sign  = tv[idx].sgn;
        in_exp   = tv[idx].ex;
        in_mant  = tv[idx].mt;
        in_rnd   = tv[idx].rm;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        chk("accept_wait", idx, 32'(k < 100), 32'd1);
        if (k < 100) begin
            sb.push_back('{idx, tv[idx].res, tv[idx].flg});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_lat(input int idx);
        send(idx);
        @(negedge clk); chk("lat_s1", idx, 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_s2", idx, 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_out", idx, 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", -1, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", -1, 32'(out_result), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("result", e.idx, 32'(out_result), 32'(e.res));
                chk("flags", e.idx, 32'(out_flags), 32'(e.flg));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b0, 5'd15, 15'h4000, RNE, 16'h4000, 4'b0000}; // carry only
        tv[1]  = '{1'b0, 5'd15, 15'h0008, RNE, 16'h1400, 4'b0000}; // cancellation
        tv[2]  = '{1'b0, 5'd1,  15'h1000, RNE, 16'h0200, 4'b0000}; // subnormal
        tv[3]  = '{1'b1, 5'd15, 15'h0000, RNE, 16'h8000, 4'b0001}; // signed zero
        tv[4]  = '{1'b0, 5'd15, 15'h200C, RNE, 16'h3C02, 4'b0010};
        tv[5]  = '{1'b0, 5'd15, 15'h2004, RNE, 16'h3C00, 4'b0010};
        tv[6]  = '{1'b0, 5'd15, 15'h2007, RTZ, 16'h3C00, 4'b0010};
        tv[7]  = '{1'b0, 5'd15, 15'h2007, RUP, 16'h3C01, 4'b0010};
        tv[8]  = '{1'b0, 5'd15, 15'h3FFE, RNE, 16'h4000, 4'b0010}; // fraction carry-out
        tv[9]  = '{1'b0, 5'd30, 15'h4000, RNE, 16'h7C00, 4'b1010};
        tv[10] = '{1'b0, 5'd30, 15'h4000, RTZ, 16'h7BFF, 4'b1010};
        tv[11] = '{1'b1, 5'd30, 15'h4000, RUP, 16'hFBFF, 4'b1010};
        tv[12] = '{1'b1, 5'd30, 15'h4000, RDN, 16'hFC00, 4'b1010};
        tv[13] = '{1'b0, 5'd1,  15'h1FFC, RNE, 16'h0400, 4'b0110}; // subnormal -> min normal
        tv[14] = '{1'b0, 5'd0,  15'h0101, RTZ, 16'h0020, 4'b0110}; // inexact subnormal
        tv[15] = '{1'b1, 5'd15, 15'h4001, RDN, 16'hC001, 4'b0010}; // sticky from carry shift
        tv[16] = '{1'b0, 5'd3,  15'h0008, RNE, 16'h0004, 4'b0000}; // shift capped by exponent

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", -1, 32'(out_valid), 32'd0);
        chk("rst_result", -1, 32'(out_result), 32'd0);
        chk("rst_flags", -1, 32'(out_flags), 32'd0);
        chk("rst_in_ready", -1, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send_lat(0);
        drain();

        for (int i = 1; i < 17; i++) send(i);
        drain();

        fork
            begin
                for (int i = 4; i < 10; i++) send(i);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", -1, 32'(in_ready), 32'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(1);
        send(2);
        @(posedge clk); #1;
        chk("pre_rst_valid", -1, 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", -1, 32'(out_valid), 32'd0);
        chk("midrst_result", -1, 32'(out_result), 32'd0);
        chk("midrst_flags", -1, 32'(out_flags), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", -1, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_lat(13);
        drain();
        repeat (5) @(negedge clk);
        chk("no_ghost", -1, 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
